// File: rtl/uob_collector_if.sv
// Unit-side readout and consumer-side FIFO signals of uob_collector.
// The collector connects through the master modport; the unit/consumer side connects through slave.
`ifndef UNIT_OUTPUT_WIDTH
`define UNIT_OUTPUT_WIDTH 4
`endif

interface uob_collector_if #(
  parameter int N_UNITS   = 4,
  parameter int OUT_WIDTH = `UNIT_OUTPUT_WIDTH
);
  logic [N_UNITS*OUT_WIDTH-1:0] unit_dout;
  logic [N_UNITS-1:0]           unit_empty;
  logic [N_UNITS-1:0]           unit_rd_en;
  logic [15:0]                  dout;
  logic                         dout_last;
  logic                         rd_en;
  logic                         empty;
  logic                         err;

  modport master (
    input  unit_dout, unit_empty, rd_en,
    output unit_rd_en, dout, dout_last, empty, err
  );

  modport slave (
    output unit_dout, unit_empty, rd_en,
    input  unit_rd_en, dout, dout_last, empty, err
  );
endinterface

// File: rtl/uob_collector.sv
// Round-robin readout of unit output buffers into a first-word-fall-through FIFO.
// Each packet is written speculatively and becomes visible only once fully received.
`ifndef UNIT_OUTPUT_WIDTH
`define UNIT_OUTPUT_WIDTH 4
`endif

module uob_collector #(
  parameter int N_UNITS   = 4,
  parameter int OUT_WIDTH = `UNIT_OUTPUT_WIDTH,
  parameter int PKT_LEN   = 12,
  parameter int FIFO_MSB  = 4
) (
  input logic             clk,
  input logic             rst,
  uob_collector_if.master io
);

  localparam int RATIO       = 16 / OUT_WIDTH;
  localparam int OUT_N_WORDS = PKT_LEN * RATIO;
  localparam int DEPTH       = 2 ** (FIFO_MSB + 1);
  localparam int PW          = FIFO_MSB + 2;
  localparam int RRW         = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int CW          = $clog2(OUT_N_WORDS + 1);
  localparam int SW          = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [15:0] SLOT_MASK = 16'((1 << OUT_WIDTH) - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HDR,
    DATA,
    COMMIT
  } state_e;

  state_e               state_q, state_d;
  logic [RRW-1:0]       rr_q, rr_d;
  logic [RRW-1:0]       sel_q, sel_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [N_UNITS-1:0]   unit_rd_en_q, unit_rd_en_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        sub_q, sub_d;
  logic [15:0]          acc_q, acc_d;
  logic                 err_q, err_d;

  logic [16:0]          mem_q [DEPTH];
  logic                 wr_en;
  logic [16:0]          wr_data;
  logic [16:0]          head;

  logic [PW-1:0]        used;
  logic [PW:0]          free;
  logic                 fifo_empty;
  logic                 pop;
  logic                 found;
  logic [RRW-1:0]       pick;
  logic [RRW-1:0]       cand;
  logic [OUT_WIDTH-1:0] cur_word;
  logic [15:0]          word_full;
  logic                 last_word;

  assign fifo_empty = (rd_ptr_q == cm_ptr_q);
  assign pop        = io.rd_en && !fifo_empty;
  assign used       = wr_ptr_q - rd_ptr_q;
  assign free       = (PW+1)'(DEPTH) - {1'b0, used};
  assign head       = mem_q[rd_ptr_q[FIFO_MSB:0]];
  assign cur_word   = OUT_WIDTH'(io.unit_dout >> (sel_q * OUT_WIDTH));
  assign last_word  = (cnt_q == CW'(OUT_N_WORDS - 1));

  assign io.unit_rd_en = unit_rd_en_q;
  assign io.empty      = fifo_empty;
  assign io.dout       = fifo_empty ? '0 : head[15:0];
  assign io.dout_last  = !fifo_empty && head[16];
  assign io.err        = err_q;

  // Round-robin search starting at rr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      cand = RRW'((32'(rr_q) + i) % unsigned'(N_UNITS));
      if (!found && !io.unit_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    unit_rd_en_d = '0;
    cnt_d        = cnt_q;
    sub_d        = sub_q;
    acc_d        = acc_q;
    err_d        = err_q;
    wr_en        = 1'b0;
    wr_data      = '0;
    word_full    = (acc_q & ~(SLOT_MASK << (sub_q * OUT_WIDTH)))
                 | (16'(cur_word) << (sub_q * OUT_WIDTH));

    unique case (state_q)
      IDLE: begin
        if (found && free >= (PW+1)'(PKT_LEN + 1)) begin
          state_d            = REQ;
          sel_d              = pick;
          unit_rd_en_d[pick] = 1'b1;
          wr_en              = 1'b1;
          wr_data            = {1'b0, 16'(pick)};
          wr_ptr_d           = wr_ptr_q + 1'b1;
          rr_d               = (pick == RRW'(N_UNITS - 1)) ? '0 : pick + 1'b1;
        end
      end
      REQ: state_d = HDR;
      HDR: begin
        if (cur_word == '1) begin
          state_d = DATA;
          cnt_d   = '0;
          sub_d   = '0;
          acc_d   = '0;
        end else begin
          err_d    = 1'b1;
          wr_ptr_d = cm_ptr_q;
          state_d  = IDLE;
        end
      end
      DATA: begin
        acc_d = word_full;
        cnt_d = cnt_q + 1'b1;
        // Every RATIO-th unit word completes a 16-bit FIFO word.
        if (sub_q == SW'(RATIO - 1)) begin
          sub_d    = '0;
          wr_en    = 1'b1;
          wr_data  = {last_word, word_full};
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          sub_d = sub_q + 1'b1;
        end
        if (last_word) state_d = COMMIT;
      end
      COMMIT: begin
        cm_ptr_d = wr_ptr_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      sel_q        <= '0;
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      unit_rd_en_q <= '0;
      cnt_q        <= '0;
      sub_q        <= '0;
      acc_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      wr_ptr_q     <= wr_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      unit_rd_en_q <= unit_rd_en_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q[FIFO_MSB:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uob_collector.sv
// Directed bench for uob_collector: behavioural unit buffers, FIFO drain with
// hand-computed packet contents, arbitration order, header error, space stall and reset abort.
module tb_uob_collector;
  localparam int N_UNITS  = 4;
  localparam int OUT_W    = 4;
  localparam int PKT_LEN  = 12;
  localparam int FIFO_MSB = 4;
  localparam int OUT_N    = PKT_LEN * (16 / OUT_W);

  logic clk;
  logic rst;

  uob_collector_if #(.N_UNITS(N_UNITS), .OUT_WIDTH(OUT_W)) bus ();

  uob_collector #(
    .N_UNITS  (N_UNITS),
    .OUT_WIDTH(OUT_W),
    .PKT_LEN  (PKT_LEN),
    .FIFO_MSB (FIFO_MSB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pkts    [N_UNITS];
  int pos     [N_UNITS];
  logic [3:0] hdr_val [N_UNITS];
  logic [3:0] gq [$];
  int multi = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unit models: header one cycle after the request, then nibbles 0..F repeating, then trailer.
  initial begin
    logic [3:0] w;
    bus.unit_dout  = '0;
    bus.unit_empty = '1;
    for (int u = 0; u < N_UNITS; u++) begin
      pkts[u]    = 0;
      pos[u]     = 0;
      hdr_val[u] = 4'hF;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < N_UNITS; u++) begin
        w = 4'h0;
        if (pos[u] == 1) w = hdr_val[u];
        else if (pos[u] >= 2 && pos[u] < 2 + OUT_N) w = 4'((pos[u] - 2) % 16);
        else if (pos[u] == 2 + OUT_N) w = 4'h5;
        bus.unit_dout[u*OUT_W +: OUT_W] = w;
        if (pos[u] > 0) pos[u] = (pos[u] == 2 + OUT_N) ? 0 : pos[u] + 1;
        if (bus.unit_rd_en[u]) begin
          pos[u] = 1;
          if (pkts[u] > 0) pkts[u]--;
        end
        bus.unit_empty[u] = (pkts[u] == 0);
      end
    end
  end

  // Grant log and back-to-back request detector.
  initial begin
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (bus.unit_rd_en != '0) begin
        gq.push_back(bus.unit_rd_en);
        if (prev != '0) multi++;
      end
      prev = bus.unit_rd_en;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] exp_word(input int u, input int i);
    if (i == 0) return 16'(u);
    case ((i - 1) % 4)
      0:       return 16'h3210;
      1:       return 16'h7654;
      2:       return 16'hBA98;
      default: return 16'hFEDC;
    endcase
  endfunction

  task automatic wait_req(input string tag, input logic [3:0] exp, input int budget);
    int k;
    k = 0;
    while (bus.unit_rd_en == '0 && k < budget) begin
      cyc(1);
      k++;
    end
    check(tag, 32'(bus.unit_rd_en), 32'(exp));
  endtask

  task automatic wait_nonempty(input string tag, input int budget);
    int k;
    k = 0;
    while (bus.empty && k < budget) begin
      cyc(1);
      k++;
    end
    check({tag, ".avail"}, 32'(bus.empty), 32'(0));
  endtask

  task automatic pop_range(input string tag, input int u, input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      check($sformatf("%s.empty%0d", tag, i), 32'(bus.empty), 32'(0));
      check($sformatf("%s.dout%0d", tag, i), 32'(bus.dout), 32'(exp_word(u, i)));
      check($sformatf("%s.last%0d", tag, i), 32'(bus.dout_last), 32'(i == PKT_LEN));
      bus.rd_en = 1'b1;
      cyc(1);
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic pop_packet(input string tag, input int u);
    wait_nonempty(tag, 300);
    pop_range(tag, u, 0, PKT_LEN);
  endtask

  initial begin
    int viol;
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst.empty", 32'(bus.empty), 32'(1));
    check("rst.err", 32'(bus.err), 32'(0));
    check("rst.unit_rd_en", 32'(bus.unit_rd_en), 32'(0));
    check("rst.dout_last", 32'(bus.dout_last), 32'(0));

    // Single packet from unit 2.
    pkts[2] = 1;
    wait_req("t1.req", 4'b0100, 20);
    cyc(1);
    check("t1.req_one_cycle", 32'(bus.unit_rd_en), 32'(0));
    cyc(48);
    check("t1.hidden_data", 32'(bus.empty), 32'(1));
    cyc(1);
    check("t1.hidden_commit", 32'(bus.empty), 32'(1));
    cyc(1);
    check("t1.visible", 32'(bus.empty), 32'(0));
    pop_range("t1", 2, 0, PKT_LEN);
    check("t1.drained", 32'(bus.empty), 32'(1));

    // Round robin 0,1,3 then wrap to 0.
    do_reset();
    gq.delete();
    pkts[0] = 1;
    pkts[1] = 1;
    pkts[3] = 1;
    pop_packet("t2.p0", 0);
    pop_packet("t2.p1", 1);
    pop_packet("t2.p3", 3);
    pkts[0] = 1;
    pkts[3] = 1;
    pop_packet("t2.w0", 0);
    pop_packet("t2.w3", 3);
    check("t2.n_grants", 32'(gq.size()), 32'(5));
    if (gq.size() == 5)
      check("t2.order", {12'h0, gq[0], gq[1], gq[2], gq[3], gq[4]}, 32'h00012818);

    // Bad header on unit 1.
    hdr_val[1] = 4'hE;
    pkts[1]    = 1;
    wait_req("t3.req", 4'b0010, 50);
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (!bus.empty) viol++;
    end
    check("t3.never_visible", 32'(viol), 32'(0));
    check("t3.err", 32'(bus.err), 32'(1));
    hdr_val[1] = 4'hF;
    pkts[2]    = 1;
    pop_packet("t3.next", 2);
    check("t3.err_sticky", 32'(bus.err), 32'(1));

    // Space check: two packets stored (26 words), third waits for free >= 13.
    do_reset();
    check("t4.err_cleared", 32'(bus.err), 32'(0));
    gq.delete();
    pkts[0] = 2;
    wait_nonempty("t4.first", 300);
    cyc(60);
    check("t4.two_grants", 32'(gq.size()), 32'(2));
    pkts[1] = 1;
    cyc(10);
    check("t4.stall_full", 32'(gq.size()), 32'(2));
    pop_range("t4.a", 0, 0, 5);
    cyc(10);
    check("t4.stall_free12", 32'(gq.size()), 32'(2));
    pop_range("t4.a", 0, 6, 6);
    wait_req("t4.req_free13", 4'b0010, 10);
    pop_range("t4.a", 0, 7, PKT_LEN);
    pop_packet("t4.b", 0);
    pop_packet("t4.c", 1);

    // Reset during DATA cycle 20 of a unit-2 packet.
    do_reset();
    pkts[2] = 1;
    wait_req("t5.req", 4'b0100, 20);
    cyc(21);
    rst  = 1'b1;
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (bus.unit_rd_en != '0) viol++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.unit_rd_en != '0 || !bus.empty) viol++;
    end
    check("t5.quiet_after_rst", 32'(viol), 32'(0));
    check("t5.empty", 32'(bus.empty), 32'(1));
    check("t5.err", 32'(bus.err), 32'(0));
    pkts[1] = 1;
    pkts[3] = 1;
    pop_packet("t5.p1", 1);
    pop_packet("t5.p3", 3);

    check("all.req_single_cycle", 32'(multi), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
